// File: rtl/piso_tx_arbiter.sv
// piso_tx_arbiter: round-robin grant of R requesters onto one MSB-first
// serializer with frame strobe and source ID.
// Optional feature: define PISO_ARB_PARITY_EN to append an even-parity bit
// after the data bits of every frame.
module piso_tx_arbiter #(
    parameter int unsigned N  = 8,
    parameter int unsigned R  = 4,
    parameter int unsigned IW = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [R-1:0]     req_valid_i,
    input  logic [R*N-1:0]   req_data_i,
    output logic [R-1:0]     req_ready_o,
    output logic             serial_o,
    output logic             frame_o,
    output logic [IW-1:0]    src_o,
    output logic             busy_o
);

    localparam int unsigned CW = $clog2(N);

`ifdef PISO_ARB_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd3
    } state_t;
`endif

    state_t          state_q;
    state_t          state_n;
    logic [N-1:0]    shift_q;
    logic [CW-1:0]   cnt_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   src_q;
`ifdef PISO_ARB_PARITY_EN
    logic            parity_q;
`endif

    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    logic [N-1:0]    grant_word;
    logic            handshake;

    // Round-robin search from the pointer, ascending with wrap; first valid wins.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_word  = '0;
        for (int unsigned i = 0; i < R; i++) begin
            idx = (32'(ptr_q) + i) % R;
            if (!grant_found && req_valid_i[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(idx);
                grant_word  = req_data_i[idx*N +: N];
            end
        end
    end

    // Ready is a one-hot decode of the winner, only offered in IDLE and out of reset.
    always_comb begin
        handshake   = (state_q == IDLE) && grant_found && !rst_i;
        req_ready_o = '0;
        for (int unsigned k = 0; k < R; k++) begin
            req_ready_o[k] = handshake && (grant_idx == IW'(k));
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state sequencing: IDLE -> SHIFT x N -> [PARITY] -> GAP -> IDLE.
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
`ifdef PISO_ARB_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = GAP;
`endif
                end
            end
`ifdef PISO_ARB_PARITY_EN
            PARITY: state_n = GAP;
`endif
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: load on handshake, shift and count down during SHIFT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            ptr_q    <= '0;
            src_q    <= '0;
`ifdef PISO_ARB_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        shift_q  <= grant_word;
                        src_q    <= grant_idx;
                        cnt_q    <= CW'(N - 1);
                        ptr_q    <= (grant_idx == IW'(R - 1)) ? '0 : grant_idx + 1'b1;
`ifdef PISO_ARB_PARITY_EN
                        parity_q <= ^grant_word;
`endif
                    end
                end
                SHIFT: begin
                    shift_q <= {shift_q[N-2:0], 1'b0};
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Line outputs decoded from registered state only.
    always_comb begin
        serial_o = 1'b0;
        frame_o  = 1'b0;
        case (state_q)
            SHIFT: begin
                serial_o = shift_q[N-1];
                frame_o  = 1'b1;
            end
`ifdef PISO_ARB_PARITY_EN
            PARITY: begin
                serial_o = parity_q;
                frame_o  = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign src_o  = src_q;

endmodule
